// File: rtl/sw_pkg.sv
// Shared types and constants for the switch event controller.
// Optional feature macro: SW_AUTOREPEAT_EN (press/auto-repeat timing).
package sw_pkg;

    localparam int N_SW = 4;
    localparam int ID_W = 2;

    // Default timing for a 12 MHz clock: 10 ms tick, 400 ms delay, 100 ms rate.
    localparam int TICK_DIV_12M     = 120000;
    localparam int REPEAT_DELAY_DEF = 40;
    localparam int REPEAT_RATE_DEF  = 10;
    localparam int CNT_W_DEF        = 8;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT,
        ST_HELD
    } sw_state_t;

endpackage

// File: rtl/sw_event_ctrl_if.sv
// Valid/ready event channel from the switch controller to the game logic.
interface sw_event_ctrl_if
    import sw_pkg::*;
();

    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic            evt_repeat;

    modport master (output evt_valid, output evt_id, output evt_repeat, input evt_ready);
    modport slave  (input evt_valid, input evt_id, input evt_repeat, output evt_ready);

endinterface

// File: rtl/sw_repeat_fsm.sv
// Per-button press / auto-repeat state machine.
// With SW_AUTOREPEAT_EN defined: ARM/IDLE/DELAY/REPEAT with tick counting.
// Without it: ARM/IDLE/HELD, press events only.
module sw_repeat_fsm
    import sw_pkg::*;
`ifdef SW_AUTOREPEAT_EN
#(
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
    parameter int CNT_W        = CNT_W_DEF
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic sw_lvl,
    input  logic tick,
    output logic evt_raise
`ifdef SW_AUTOREPEAT_EN
    ,
    output logic evt_rep
`endif
);

    sw_state_t state_reg, state_next;

`ifdef SW_AUTOREPEAT_EN
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // State and tick counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_ARM;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state, counter and one-cycle event strobes; release beats a tick.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        evt_raise  = 1'b0;
        evt_rep    = 1'b0;
        case (state_reg)
            ST_ARM:  if (!sw_lvl) state_next = ST_IDLE;
            ST_IDLE: begin
                if (sw_lvl) begin
                    evt_raise  = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (!sw_lvl) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    if (cnt_reg == CNT_W'(REPEAT_DELAY - 1)) begin
                        evt_raise  = 1'b1;
                        evt_rep    = 1'b1;
                        cnt_next   = '0;
                        state_next = ST_REPEAT;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_REPEAT: begin
                if (!sw_lvl) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    if (cnt_reg == CNT_W'(REPEAT_RATE - 1)) begin
                        evt_raise = 1'b1;
                        evt_rep   = 1'b1;
                        cnt_next  = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: state_next = ST_ARM;
        endcase
    end
`else
    // The tick has no role once repeat timing is compiled out.
    logic unused_tick;
    assign unused_tick = tick;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_ARM;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and press strobe; HELD only exits on release.
    always_comb begin
        state_next = state_reg;
        evt_raise  = 1'b0;
        case (state_reg)
            ST_ARM:  if (!sw_lvl) state_next = ST_IDLE;
            ST_IDLE: begin
                if (sw_lvl) begin
                    evt_raise  = 1'b1;
                    state_next = ST_HELD;
                end
            end
            ST_HELD: if (!sw_lvl) state_next = ST_IDLE;
            default: state_next = ST_ARM;
        endcase
    end
`endif

endmodule

// File: rtl/sw_event_ctrl.sv
// Switch event controller: scan tick divider, per-button FSMs, one-deep
// pending store per button, round-robin arbiter and valid/ready output.
// Optional feature macro: SW_AUTOREPEAT_EN.
module sw_event_ctrl
    import sw_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_12M
`ifdef SW_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
    parameter int CNT_W        = CNT_W_DEF
`endif
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_SW-1:0]       sw_lvl,
    output logic                  tick,
    sw_event_ctrl_if.master       evt,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0]   tick_cnt_reg;
    logic [N_SW-1:0] raise;
    logic [N_SW-1:0] pend_reg, pend_next;
    logic [N_SW-1:0] pop;
    logic [N_SW-1:0] drop;
    logic [ID_W-1:0] rr_ptr_reg;
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] idx;
    logic            found;
    logic            load;
    logic            evt_valid_reg;
    logic [ID_W-1:0] evt_id_reg;
    logic            overrun_reg;

    // Free-running scan divider; tick marks the last count of each period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_reg <= '0;
        end else if (tick_cnt_reg == TW'(TICK_DIV - 1)) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TW'(1);
        end
    end

    assign tick = (tick_cnt_reg == TW'(TICK_DIV - 1));

`ifdef SW_AUTOREPEAT_EN
    logic [N_SW-1:0] rep;
    logic [N_SW-1:0] pend_rep_reg, pend_rep_next;
    logic            evt_repeat_reg;

    generate
        for (genvar gi = 0; gi < N_SW; gi++) begin : g_fsm
            sw_repeat_fsm #(
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_RATE  (REPEAT_RATE),
                .CNT_W        (CNT_W)
            ) u_fsm (
                .clk       (clk),
                .reset     (reset),
                .sw_lvl    (sw_lvl[gi]),
                .tick      (tick),
                .evt_raise (raise[gi]),
                .evt_rep   (rep[gi])
            );
        end
    endgenerate
`else
    generate
        for (genvar gi = 0; gi < N_SW; gi++) begin : g_fsm
            sw_repeat_fsm u_fsm (
                .clk       (clk),
                .reset     (reset),
                .sw_lvl    (sw_lvl[gi]),
                .tick      (tick),
                .evt_raise (raise[gi])
            );
        end
    endgenerate
`endif

    assign load = !evt_valid_reg || evt.evt_ready;

    // Round-robin pick: first pending button at or after rr_ptr, wrapping.
    // N_SW is a power of two, so ID_W-bit addition wraps naturally.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < N_SW; k++) begin
            idx = rr_ptr_reg + ID_W'(k);
            if (!found && pend_reg[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // One-hot pop of the granted pending slot.
    always_comb begin
        pop = '0;
        if (load && found) pop[sel] = 1'b1;
    end

    // Pending store: a new event is dropped only if the slot stays occupied.
    always_comb begin
        pend_next = pend_reg & ~pop;
        drop      = '0;
`ifdef SW_AUTOREPEAT_EN
        pend_rep_next = pend_rep_reg;
`endif
        for (int i = 0; i < N_SW; i++) begin
            if (raise[i]) begin
                if (pend_reg[i] && !pop[i]) begin
                    drop[i] = 1'b1;
                end else begin
                    pend_next[i] = 1'b1;
`ifdef SW_AUTOREPEAT_EN
                    pend_rep_next[i] = rep[i];
`endif
                end
            end
        end
    end

    // Pending store and sticky overrun; a drop beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_reg    <= '0;
            overrun_reg <= 1'b0;
        end else begin
            pend_reg <= pend_next;
            if (|drop) begin
                overrun_reg <= 1'b1;
            end else if (clr_overrun) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    // Output register and round-robin pointer; held while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_valid_reg <= 1'b0;
            evt_id_reg    <= '0;
            rr_ptr_reg    <= '0;
        end else if (load) begin
            evt_valid_reg <= found;
            if (found) begin
                evt_id_reg <= sel;
                rr_ptr_reg <= sel + ID_W'(1);
            end
        end
    end

`ifdef SW_AUTOREPEAT_EN
    // Repeat flag travels with the pending slot into the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_rep_reg   <= '0;
            evt_repeat_reg <= 1'b0;
        end else begin
            pend_rep_reg <= pend_rep_next;
            if (load && found) evt_repeat_reg <= pend_rep_reg[sel];
        end
    end

    assign evt.evt_repeat = evt_repeat_reg;
`else
    assign evt.evt_repeat = 1'b0;
`endif

    assign evt.evt_valid = evt_valid_reg;
    assign evt.evt_id    = evt_id_reg;
    assign overrun       = overrun_reg;

endmodule
